// File: rtl/cbus_line_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cbus_line_master_pkg
// Purpose  : CBus request/response types, burst encodings and line-master FSM
//            states shared by the line master and its bench.
// Revision : 1.0 - initial release
// ============================================================================
package cbus_line_master_pkg;

    localparam int LINE_BEATS_DEFAULT = 8;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic        is_write;
        msize_t      size;
        logic [1:0]  burst;
        logic [7:0]  len;
        logic [7:0]  strobe;
        logic [63:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } line_state_t;

endpackage
`default_nettype wire

// File: rtl/cbus_line_master.sv
`default_nettype none
// ============================================================================
// Module   : cbus_line_master
// Purpose  : Turns whole-line refill/writeback requests into CBus INCR bursts
//            of 8-byte beats. Optional single-beat uncached accesses are
//            enabled by defining CBUS_LINE_MASTER_UNCACHED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cbus_line_master
    import cbus_line_master_pkg::*;
#(
    parameter int LINE_BEATS = LINE_BEATS_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     line_valid_i,
    output logic                     line_ready_o,
    input  logic                     line_is_write_i,
    input  logic                     line_uncached_i,
    input  logic [63:0]              line_addr_i,
    input  msize_t                   line_size_i,
    input  logic [7:0]               line_strobe_i,
    input  logic [LINE_BEATS*64-1:0] line_wdata_i,
    output logic                     line_resp_valid_o,
    output logic [LINE_BEATS*64-1:0] line_rdata_o,
    output cbus_req_t                oreq_o,
    input  cbus_resp_t               oresp_i
);

    localparam int              LINE_BYTES = LINE_BEATS * 8;
    localparam int              OFS_BITS   = $clog2(LINE_BYTES);
    localparam int              IDX_W      = $clog2(LINE_BEATS);
    localparam int              CNT_W      = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);
    localparam logic [63:0]     LINE_MASK  = ~((64'd1 << OFS_BITS) - 64'd1);

    line_state_t              state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [63:0]              addr_q;
    logic                     is_write_q;
    logic [LINE_BEATS*64-1:0] wdata_q;
    logic [LINE_BEATS*64-1:0] rdata_q;
    logic [IDX_W+5:0]         w_lsb;
    logic                     w_unc;

`ifdef CBUS_LINE_MASTER_UNCACHED_EN
    logic       unc_q;
    msize_t     size_q;
    logic [7:0] strobe_q;
    assign w_unc = unc_q;
`else
    logic w_unused_cfg;
    assign w_unc        = 1'b0;
    assign w_unused_cfg = ^{line_uncached_i, line_size_i, line_strobe_i};
`endif

    assign w_lsb        = {cnt_q[IDX_W-1:0], 6'd0};
    assign line_rdata_o = rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        line_ready_o      = 1'b0;
        line_resp_valid_o = 1'b0;
        oreq_o            = '0;
        case (state_q)
            IDLE: begin
                line_ready_o = rst_ni;
                if (line_valid_i) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                oreq_o.valid    = 1'b1;
                oreq_o.addr     = addr_q & LINE_MASK;
                oreq_o.is_write = is_write_q;
                oreq_o.size     = MSIZE8;
                oreq_o.burst    = AXI_BURST_INCR;
                oreq_o.len      = 8'(LINE_BEATS - 1);
                oreq_o.strobe   = is_write_q ? 8'hFF : 8'h00;
                oreq_o.data     = wdata_q[w_lsb +: 64];
`ifdef CBUS_LINE_MASTER_UNCACHED_EN
                if (unc_q) begin
                    oreq_o.addr   = addr_q;
                    oreq_o.size   = size_q;
                    oreq_o.burst  = AXI_BURST_FIXED;
                    oreq_o.len    = 8'd0;
                    oreq_o.strobe = is_write_q ? strobe_q : 8'h00;
                    oreq_o.data   = wdata_q[63:0];
                end
`endif
                if (oresp_i.ready) begin
                    if (oresp_i.last || w_unc) begin
                        state_d = DONE;
                    end else if (cnt_q != LAST_BEAT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                line_resp_valid_o = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q     <= '0;
            is_write_q <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
`ifdef CBUS_LINE_MASTER_UNCACHED_EN
            unc_q      <= 1'b0;
            size_q     <= MSIZE1;
            strobe_q   <= '0;
`endif
        end else begin
            if (state_q == IDLE && line_valid_i) begin
                addr_q     <= line_addr_i;
                is_write_q <= line_is_write_i;
                wdata_q    <= line_wdata_i;
`ifdef CBUS_LINE_MASTER_UNCACHED_EN
                unc_q      <= line_uncached_i;
                size_q     <= line_size_i;
                strobe_q   <= line_strobe_i;
`endif
            end
            // Uncached reads land in beat 0 because the counter is still zero.
            if (state_q == BUSY && oresp_i.ready && !is_write_q) begin
                rdata_q[w_lsb +: 64] <= oresp_i.data;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni && state_q == BUSY && oresp_i.ready && !w_unc) begin
            if (oresp_i.last && cnt_q != LAST_BEAT)
                $error("cbus_line_master: last on beat %0d", cnt_q);
            if (!oresp_i.last && cnt_q == LAST_BEAT)
                $error("cbus_line_master: burst overran without last");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cbus_line_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_cbus_line_master
// Purpose  : Self-checking bench with a line-memory responder and a scoreboard
//            of expected beats for cbus_line_master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cbus_line_master;
    import cbus_line_master_pkg::*;

    localparam int NB = 8;
`ifdef CBUS_LINE_MASTER_UNCACHED_EN
    localparam bit UNC_EN = 1'b1;
`else
    localparam bit UNC_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            line_valid = 1'b0;
    logic            line_ready;
    logic            line_is_write = 1'b0;
    logic            line_uncached = 1'b0;
    logic [63:0]     line_addr = '0;
    msize_t          line_size = MSIZE8;
    logic [7:0]      line_strobe = '0;
    logic [NB*64-1:0] line_wdata = '0;
    logic            line_resp_valid;
    logic [NB*64-1:0] line_rdata;
    cbus_req_t       oreq;
    cbus_resp_t      oresp = '0;

    int              vectors = 0;
    int              miscompares = 0;
    int              cyc_abs = 0;
    int              last_acc = 0;
    logic [63:0]     mem [NB];
    logic [NB*64-1:0] exp_rdata = '0;
    logic [63:0]     sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_abs <= cyc_abs + 1;

    cbus_line_master #(.LINE_BEATS(NB)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .line_valid_i     (line_valid),
        .line_ready_o     (line_ready),
        .line_is_write_i  (line_is_write),
        .line_uncached_i  (line_uncached),
        .line_addr_i      (line_addr),
        .line_size_i      (line_size),
        .line_strobe_i    (line_strobe),
        .line_wdata_i     (line_wdata),
        .line_resp_valid_o(line_resp_valid),
        .line_rdata_o     (line_rdata),
        .oreq_o           (oreq),
        .oresp_i          (oresp)
    );

    // One line transaction with the bench acting as an SRAM-style responder.
    task automatic do_line(input logic wr, input logic unc, input logic [63:0] addr,
                           input msize_t sz, input logic [7:0] strb, input int stall_at,
                           input int stall_n, input int rst_at, input logic hold,
                           input int exp_done);
        cbus_req_t er;
        int        beat = 0;
        int        stalls = 0;
        int        cyc = 1;
        int        nb;
        bit        eu;
        bit        done = 1'b0;
        bit        aborted = 1'b0;
        logic [63:0] e;
        logic [63:0] a;
        eu = unc && UNC_EN;
        nb = eu ? 1 : NB;
        @(negedge clk);
        vectors++;
        if (line_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_before_req: got %b exp 1", line_ready);
        end
        line_valid    = 1'b1;
        line_is_write = wr;
        line_uncached = unc;
        line_addr     = addr;
        line_size     = sz;
        line_strobe   = strb;
        for (int i = 0; i < nb; i++)
            sb.push_back(wr ? line_wdata[i*64 +: 64] : mem[i]);
        er          = '0;
        er.valid    = 1'b1;
        er.addr     = eu ? addr : {addr[63:6], 6'd0};
        er.is_write = wr;
        er.size     = eu ? sz : MSIZE8;
        er.burst    = eu ? AXI_BURST_FIXED : AXI_BURST_INCR;
        er.len      = eu ? 8'd0 : 8'd7;
        er.strobe   = wr ? (eu ? strb : 8'hFF) : 8'h00;
        @(negedge clk);
        last_acc = cyc_abs;
        if (!hold) line_valid = 1'b0;
        while (!done && !aborted && cyc < 64) begin
            if (line_resp_valid === 1'b1) begin
                vectors++;
                if (cyc !== exp_done) begin
                    miscompares++;
                    $display("FAIL resp_cycle: got %0d exp %0d", cyc, exp_done);
                end
                vectors++;
                if ({oreq.valid, line_ready} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL done_idle: got valid/ready %b exp 00", {oreq.valid, line_ready});
                end
                oresp = '0;
                done = 1'b1;
            end else begin
                er.data = line_wdata[beat*64 +: 64];
                vectors++;
                if (oreq !== er || {line_ready, line_resp_valid} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL beat%0d_req: got %h rdy %b exp %h", beat, oreq, line_ready, er);
                end
                if (beat == rst_at) begin
                    #2 rst_n = 1'b0;
                    #1;
                    vectors++;
                    if ({oreq.valid, line_ready, line_resp_valid} !== 3'b000 || line_rdata !== '0) begin
                        miscompares++;
                        $display("FAIL reset_abort: got valid/rdy/resp %b rdata0 %h exp 000/0",
                                 {oreq.valid, line_ready, line_resp_valid}, line_rdata[63:0]);
                    end
                    aborted = 1'b1;
                end else if (beat == stall_at && stalls < stall_n) begin
                    oresp.ready = 1'b0;
                    stalls++;
                end else begin
                    oresp.ready = 1'b1;
                    oresp.last  = (beat == nb - 1);
                    oresp.data  = mem[beat];
                    if (wr) mem[beat] = oreq.data;
                    beat++;
                end
                if (!aborted) begin
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        if (aborted) begin
            oresp = '0;
            line_valid = 1'b0;
            sb.delete();
            exp_rdata = '0;
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                vectors++;
                if (line_resp_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL resp_in_reset: got %b exp 0", line_resp_valid);
                end
            end
            rst_n = 1'b1;
            #1;
            vectors++;
            if (line_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL ready_after_reset: got %b exp 1", line_ready);
            end
        end else if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: got no resp_valid within 64 cycles exp cycle %0d", exp_done);
            oresp = '0;
            sb.delete();
        end else begin
            for (int i = 0; i < nb; i++) begin
                e = sb.pop_front();
                a = wr ? mem[i] : line_rdata[i*64 +: 64];
                if (!wr) exp_rdata[i*64 +: 64] = e;
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL %s_word%0d: got %h exp %h", wr ? "wb" : "rd", i, a, e);
                end
            end
            vectors++;
            if (line_rdata !== exp_rdata) begin
                miscompares++;
                $display("FAIL rdata_hold: got %h exp %h", line_rdata, exp_rdata);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({line_ready, line_resp_valid} !== 2'b00 || oreq !== '0 || line_rdata !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got rdy/resp %b oreq %h exp 00/0",
                     {line_ready, line_resp_valid}, oreq);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (line_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_out_of_reset: got %b exp 1", line_ready);
        end
    endtask

    task automatic test_refill();
        for (int i = 0; i < NB; i++) begin
            mem[i] = 64'h1000 + 64'(i);
            line_wdata[i*64 +: 64] = {$urandom, $urandom};
        end
        do_line(1'b0, 1'b0, 64'h8000_0048, MSIZE8, 8'h00, -1, 0, -1, 1'b0, NB + 1);
    endtask

    task automatic test_writeback();
        for (int i = 0; i < NB; i++) begin
            mem[i] = 64'hDEAD_0000 + 64'(i);
            line_wdata[i*64 +: 64] = 64'hA5A5_0000 + 64'(i);
        end
        do_line(1'b1, 1'b0, 64'h8000_0100, MSIZE8, 8'h00, -1, 0, -1, 1'b0, NB + 1);
    endtask

    task automatic test_stall();
        for (int i = 0; i < NB; i++) begin
            mem[i] = 64'h3000 + 64'(i);
            line_wdata[i*64 +: 64] = {$urandom, $urandom};
        end
        do_line(1'b0, 1'b0, 64'h8000_0200, MSIZE8, 8'h00, 4, 3, -1, 1'b0, NB + 4);
    endtask

    task automatic test_back_to_back();
        int first_acc;
        for (int i = 0; i < NB; i++) line_wdata[i*64 +: 64] = 64'hB0B0_0000 + 64'(i);
        do_line(1'b1, 1'b0, 64'h8000_0300, MSIZE8, 8'h00, -1, 0, -1, 1'b1, NB + 1);
        first_acc = last_acc;
        for (int i = 0; i < NB; i++) mem[i] = 64'h6000 + 64'(i);
        do_line(1'b0, 1'b0, 64'h8000_0340, MSIZE8, 8'h00, -1, 0, -1, 1'b0, NB + 1);
        vectors++;
        if (last_acc - first_acc !== NB + 2) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d exp %0d", last_acc - first_acc, NB + 2);
        end
    endtask

    task automatic test_reset_midburst();
        for (int i = 0; i < NB; i++) mem[i] = 64'h4000 + 64'(i);
        do_line(1'b0, 1'b0, 64'h8000_0400, MSIZE8, 8'h00, -1, 0, 3, 1'b0, NB + 1);
        for (int i = 0; i < NB; i++) mem[i] = 64'h5000 + 64'(i);
        do_line(1'b0, 1'b0, 64'h8000_0440, MSIZE8, 8'h00, -1, 0, -1, 1'b0, NB + 1);
    endtask

    task automatic test_uncached();
        for (int i = 0; i < NB; i++) mem[i] = 64'h7700_0000 + 64'(i);
        if (UNC_EN)
            do_line(1'b0, 1'b1, 64'h4060_0008, MSIZE4, 8'h0F, -1, 0, -1, 1'b0, 2);
        else
            do_line(1'b0, 1'b1, 64'h4060_0008, MSIZE4, 8'h0F, -1, 0, -1, 1'b0, NB + 1);
    endtask

    initial begin
        test_reset();
        test_refill();
        test_writeback();
        test_stall();
        test_back_to_back();
        test_reset_midburst();
        test_uncached();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cbus_line_master.md
Name: cbus_line_master

Overview:
- CBus initiator that turns whole-cache-line refill and writeback requests into INCR bursts of 8-byte beats.
- Sits between the L1 cache miss logic and the CBus arbiter, and drives the same CBus that SRAM/MMIO responders serve.
- Cache side uses a one-line-at-a-time valid/ready request and a single-cycle response pulse.

Parameters:
- LINE_BEATS, 8, 64-bit beats per line; power of two, 2..16.
- LINE_BYTES, LINE_BEATS*8, derived; line size in bytes.
- OFS_BITS, $clog2(LINE_BYTES), derived; offset bits cleared from line addresses.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- line_valid  in  1  cache requests a line transfer
- line_ready  out  1  master can accept a request
- line_is_write  in  1  1 = writeback, 0 = refill
- line_uncached  in  1  single-beat uncached access (see Optional Feature)
- line_addr  in  64  byte address; low OFS_BITS ignored unless uncached
- line_size  in  msize_t  uncached access size
- line_strobe  in  8  uncached write byte strobe
- line_wdata  in  LINE_BEATS*64  writeback data; beat i at bits [64i+63:64i]
- line_resp_valid  out  1  one-cycle completion pulse
- line_rdata  out  LINE_BEATS*64  refill data; beat 0 only for uncached
- oreq  out  cbus_req_t  CBus request
- oresp  in  cbus_resp_t  CBus response

Behaviour:
- States: IDLE, BUSY, DONE, with a beat counter of width $clog2(LINE_BEATS)+1.
- Reset values: state=IDLE; oreq all zero (valid=0); line_ready=0 while reset is low, 1 once out of reset; line_resp_valid=0; line_rdata=0; counter=0.
- IDLE:
  - line_ready=1 and oreq.valid=0.
  - On line_valid&&line_ready: latch addr, is_write, uncached, size, strobe and wdata; clear counter; go BUSY next cycle.
- BUSY:
  - oreq.valid=1.
  - oreq.addr = latched addr with low OFS_BITS zeroed.
  - oreq.burst=AXI_BURST_INCR, oreq.size=MSIZE8, oreq.len=LINE_BEATS-1.
  - oreq.is_write = latched is_write; oreq.strobe = 8'hFF for write, 8'h00 for read.
  - oreq.data = wdata beat[counter].
  - All oreq fields except data stay stable for the whole burst.
- Per beat: a beat completes in a cycle with oresp.ready=1.
  - Read: line_rdata beat[counter] <= oresp.data.
  - Then counter++.
- End of burst:
  - The burst ends on the beat where oresp.last=1; go DONE.
  - If last arrives with counter != LINE_BEATS-1: simulation error, still go DONE.
  - If counter would pass LINE_BEATS-1 without last: simulation error, stay BUSY and hold data at the last beat.
- Stall: oresp.ready=0 holds counter and oreq unchanged; no timeout.
- DONE: line_resp_valid=1 for exactly one cycle; oreq.valid=0; line_ready=0; return to IDLE.
- A forced idle cycle on CBus (oreq.valid=0 in DONE and IDLE) separates transactions, so the responder sees a fresh start.
- Latency with an always-ready responder: request accepted in cycle 0, beats in cycles 1..LINE_BEATS, resp_valid in cycle LINE_BEATS+1. Minimum request spacing is LINE_BEATS+2 cycles.
- line_rdata holds its value until the next read beat writes it. Writebacks leave line_rdata unchanged.
- Reset asserted mid-burst: return to IDLE immediately (asynchronous), oreq.valid drops in the same instant, no resp pulse, partial line_rdata is cleared.
- line_valid while not in IDLE is ignored (line_ready=0); the requester holds its request.

Optional Feature:
- Macro CBUS_LINE_MASTER_UNCACHED_EN.
- Defined, when latched uncached=1:
  - oreq.burst=AXI_BURST_FIXED, oreq.len=0.
  - oreq.addr = full latched addr; oreq.size = latched size.
  - oreq.strobe = latched strobe for write, 0 for read; oreq.data = wdata beat 0.
  - The first ready beat completes; read data goes to rdata beat 0; go DONE.
- Not defined: line_uncached, line_size and line_strobe are ignored; every request is a full-line burst.

Decomposition:
- common package: reuse cbus_req_t, cbus_resp_t, msize_t and the AXI_BURST_* constants. Add the line_state_t enum {IDLE, BUSY, DONE} and a LINE_BEATS_DEFAULT constant.
- No sub-module: beat mux/demux and FSM stay in one module.

Test Plan:
- Refill, addr 0x8000_0048, always-ready SRAM-model responder holding 0x1000+i at beat i -> oreq.addr=0x8000_0040, len=7; line_rdata beat i = 0x1000+i; resp_valid in cycle 9.
- Writeback, wdata beat i = 0xA5A5_0000+i -> 8 write beats with strobe 0xFF; model memory words 0..7 match; resp_valid pulse; line_rdata unchanged.
- Responder drops ready for 3 cycles at beat 4 -> counter holds and oreq stays stable; completion at cycle 12; data correct.
- Two requests back-to-back -> oreq.valid is low for at least one cycle between bursts; line_ready=0 from accept through DONE.
- Reset driven low at beat 3 of a refill -> oreq.valid=0 immediately; no resp pulse; after release, a new refill completes correctly.
- UNCACHED_EN: uncached read at 0x4060_0008, size MSIZE4 -> single FIXED beat, len=0; rdata beat 0 = responder data; resp_valid in cycle 2.
